// File: rtl/regfile_writeback_ctrl.sv
// Register-file writeback controller: FIFO-buffered write requests drained one per
// cycle, plus a zero-fill sequencer. Optional macro: REGFILE_WB_ZERO_FILTER_EN.
module regfile_writeback_ctrl #(
   parameter int WIDTH    = 32,
   parameter int SELECTOR = 5,
   parameter int DEPTH    = 4,
   localparam int PW      = $clog2(DEPTH + 1),
   localparam int PTR_W   = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [SELECTOR-1:0] req_addr_i,
   input  logic [WIDTH-1:0]    req_data_i,
   input  logic                clear_start_i,
   output logic                busy_o,
   output logic [PW-1:0]       pending_o,
   output logic                Reg_Write_o,
   output logic [SELECTOR-1:0] Write_Register_o,
   output logic [WIDTH-1:0]    Write_Data_o
);

   typedef enum logic {IDLE, CLEAR} state_t;

`ifdef REGFILE_WB_ZERO_FILTER_EN
   localparam logic [SELECTOR-1:0] CLR_FIRST = SELECTOR'(1);
`else
   localparam logic [SELECTOR-1:0] CLR_FIRST = '0;
`endif

   state_t              state;
   logic                clear_pending;
   logic [SELECTOR-1:0] clr_addr;

   logic [SELECTOR-1:0] fifo_addr [DEPTH];
   logic [WIDTH-1:0]    fifo_data [DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [PW-1:0]       count;
   logic                accept, push, pop;

   assign req_ready_o = (count < PW'(DEPTH)) && (state == IDLE) && !clear_pending;
   assign accept      = req_valid_i && req_ready_o;
`ifdef REGFILE_WB_ZERO_FILTER_EN
   // Address-0 writes complete the handshake but are dropped.
   assign push        = accept && (req_addr_i != '0);
`else
   assign push        = accept;
`endif
   assign pop         = (state == IDLE) && (count != '0);

   assign pending_o   = count;
   // Reg_Write_o is included so busy covers the final write cycle itself.
   assign busy_o      = (count != '0) || clear_pending || (state == CLEAR) || Reg_Write_o;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= req_addr_i;
         fifo_data[wr_ptr] <= req_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         clear_pending    <= 1'b0;
         clr_addr         <= '0;
         Reg_Write_o      <= 1'b0;
         Write_Register_o <= '0;
         Write_Data_o     <= '0;
      end else begin
         Reg_Write_o <= 1'b0;
         case (state)
            IDLE: begin
               if (clear_start_i && !clear_pending)
                  clear_pending <= 1'b1;
               if (count != '0) begin
                  Reg_Write_o      <= 1'b1;
                  Write_Register_o <= fifo_addr[rd_ptr];
                  Write_Data_o     <= fifo_data[rd_ptr];
               end else if (clear_pending) begin
                  state         <= CLEAR;
                  clear_pending <= 1'b0;
                  clr_addr      <= CLR_FIRST;
               end
            end
            CLEAR: begin
               Reg_Write_o      <= 1'b1;
               Write_Register_o <= clr_addr;
               Write_Data_o     <= '0;
               clr_addr         <= clr_addr + 1'b1;
               if (clr_addr == '1)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Bench for regfile_writeback_ctrl: queue-based reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_regfile_writeback_ctrl;
   localparam int WIDTH = 32, SELECTOR = 5, DEPTH = 4, NREG = 32;
`ifdef REGFILE_WB_ZERO_FILTER_EN
   localparam int FIRST = 1;
`else
   localparam int FIRST = 0;
`endif
   localparam int NCLR = NREG - FIRST;

   logic clk = 0, rst = 1;
   logic req_valid_i = 0, clear_start_i = 0;
   logic [SELECTOR-1:0] req_addr_i = '0;
   logic [WIDTH-1:0] req_data_i = '0;
   logic req_ready_o, busy_o, Reg_Write_o;
   logic [2:0] pending_o;
   logic [SELECTOR-1:0] Write_Register_o;
   logic [WIDTH-1:0] Write_Data_o;

   regfile_writeback_ctrl #(.WIDTH(WIDTH), .SELECTOR(SELECTOR), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i), .clear_start_i(clear_start_i),
      .busy_o(busy_o), .pending_o(pending_o), .Reg_Write_o(Reg_Write_o),
      .Write_Register_o(Write_Register_o), .Write_Data_o(Write_Data_o));

   always #5 clk = ~clk;

   int pass_cnt = 0, total_cnt = 0;
   int wr_cnt = 0, zero_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   // Reference model: a queue of requests, a pending-clear flag and a clear index.
   typedef struct { logic [SELECTOR-1:0] a; logic [WIDTH-1:0] d; } req_t;
   req_t q[$];
   bit   m_pend = 0, m_clr = 0, m_we = 0;
   int   m_idx = 0;
   logic [SELECTOR-1:0] m_addr = '0;
   logic [WIDTH-1:0]    m_data = '0;

   function automatic bit m_ready();
      return (q.size() < DEPTH) && !m_clr && !m_pend;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete(); m_pend = 0; m_clr = 0; m_we = 0; m_idx = 0; m_addr = '0; m_data = '0;
      end else begin
         bit acc, pre_pend, pre_clr, had;
         req_t r;
         acc = req_valid_i && m_ready();
         pre_pend = m_pend; pre_clr = m_clr; had = q.size() > 0;
         m_we = 0;
         if (pre_clr) begin
            m_we = 1; m_addr = SELECTOR'(m_idx); m_data = '0;
            m_idx++;
            if (m_idx == NREG) m_clr = 0;
         end else if (had) begin
            r = q.pop_front(); m_we = 1; m_addr = r.a; m_data = r.d;
         end else if (pre_pend) begin
            m_clr = 1; m_idx = FIRST; m_pend = 0;
         end
         if (clear_start_i && !pre_clr && !pre_pend) m_pend = 1;
`ifdef REGFILE_WB_ZERO_FILTER_EN
         if (acc && req_addr_i != '0) q.push_back('{req_addr_i, req_data_i});
`else
         if (acc) q.push_back('{req_addr_i, req_data_i});
`endif
      end
   end

   always @(negedge clk) begin
      chk("we", Reg_Write_o, m_we);
      chk("waddr", Write_Register_o, m_addr);
      chk("wdata", Write_Data_o, m_data);
      chk("pending", pending_o, q.size());
      chk("ready", req_ready_o, m_ready());
      chk("busy", busy_o, (q.size() != 0) || m_pend || m_clr || m_we);
      if (Reg_Write_o) begin
         wr_cnt++;
         if (Write_Data_o == 0) zero_cnt++;
      end
   end

   task automatic cyc();
      @(negedge clk); #1;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy_o && n < max) begin cyc(); n++; end
      chk("idle_bound", n < max, 1);
   endtask

   initial begin
      int w0, z0, n;
      #2;
      chk("rst_we", Reg_Write_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_pending", pending_o, 0);
      chk("rst_data", Write_Data_o, 0);
      cyc(); cyc(); rst = 0;

      // single request latency
      cyc(); req_valid_i = 1; req_addr_i = 5; req_data_i = 32'hDEADBEEF;
      cyc(); req_valid_i = 0; chk("t1_we_early", Reg_Write_o, 0);
      cyc(); chk("t1_we", Reg_Write_o, 1); chk("t1_addr", Write_Register_o, 5);
      chk("t1_data", Write_Data_o, 32'hDEADBEEF);
      cyc(); chk("t1_we_once", Reg_Write_o, 0);

      // six back-to-back requests
      w0 = wr_cnt;
      for (int i = 0; i < 6; i++) begin
         chk("t2_ready", req_ready_o, 1);
         chk("t2_pend_le1", pending_o <= 1, 1);
         req_valid_i = 1; req_addr_i = SELECTOR'(i + 1); req_data_i = 32'h111 * (i + 1);
         cyc();
      end
      req_valid_i = 0;
      wait_idle(20);
      chk("t2_writes", wr_cnt - w0, 6);

      // drain then clear; refused push and ignored second pulse
      w0 = wr_cnt; z0 = zero_cnt;
      req_valid_i = 1; req_addr_i = 3; req_data_i = 32'hA;
      cyc(); req_addr_i = 4; req_data_i = 32'hB; clear_start_i = 1;
      cyc(); clear_start_i = 0; req_addr_i = 9; req_data_i = 32'hC;
      chk("t3_ready_blocked", req_ready_o, 0);
      cyc(); req_valid_i = 0;
      cyc(); cyc(); clear_start_i = 1;
      cyc(); clear_start_i = 0;
      wait_idle(100);
      chk("t3_writes", wr_cnt - w0, 2 + NCLR);
      chk("t3_zero_writes", zero_cnt - z0, NCLR);
      chk("t3_busy_end", busy_o, 0);

      // reset during clear at address 12
      clear_start_i = 1; cyc(); clear_start_i = 0;
      n = 0;
      while (!(Reg_Write_o && Write_Register_o == 12) && n < 100) begin cyc(); n++; end
      chk("t4_reach12", n < 100, 1);
      rst = 1; #1;
      chk("t4_we0", Reg_Write_o, 0); chk("t4_addr0", Write_Register_o, 0);
      chk("t4_busy0", busy_o, 0); chk("t4_pend0", pending_o, 0);
      cyc(); rst = 0;
      chk("t4_ready", req_ready_o, 1);
      w0 = wr_cnt;
      repeat (5) cyc();
      chk("t4_no_writes", wr_cnt - w0, 0);

      // address-0 request
      w0 = wr_cnt;
      chk("t5_ready", req_ready_o, 1);
      req_valid_i = 1; req_addr_i = 0; req_data_i = 32'h1;
      cyc(); req_valid_i = 0;
      repeat (3) cyc();
`ifdef REGFILE_WB_ZERO_FILTER_EN
      chk("t5_addr0_dropped", wr_cnt - w0, 0);
`else
      chk("t5_addr0_written", wr_cnt - w0, 1);
`endif
      z0 = zero_cnt;
      clear_start_i = 1; cyc(); clear_start_i = 0;
      wait_idle(100);
      chk("t5_clear_len", zero_cnt - z0, NCLR);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end
endmodule
